// File: rtl/blram_arbiter.sv
// blram_arbiter: two-port req/gnt arbiter in front of a single-port, one-cycle-read block RAM.
// Define BLRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module blram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic own_v, own_b, s1_v, s1_b, s2_v, s2_b, hold, tie_a, pol_a;
`ifdef BLRAM_ARB_RR_EN
    logic ptr_b;
    assign pol_a = ptr_b;
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr_b <= 1'b1;
        else if (a_gnt || b_gnt) ptr_b <= b_gnt;
`else
    assign pol_a = 1'b1;
`endif
    // A releasing owner still wins the tie in its release cycle
    always_comb begin
        hold  = own_v && (own_b ? b_lock : a_lock);
        tie_a = own_v ? !own_b : pol_a;
        a_gnt = a_req && (hold ? !own_b : (!b_req || tie_a));
        b_gnt = b_req && (hold ? own_b : (!a_req || !tie_a));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            {s1_v, s1_b, s2_v, s2_b} <= '0;
            {own_v, own_b} <= '0;
        end else begin
            mem_we <= (a_gnt && a_we) || (b_gnt && b_we);
            if (a_gnt || b_gnt) begin
                mem_addr  <= b_gnt ? b_addr : a_addr;
                mem_wdata <= b_gnt ? b_wdata : a_wdata;
            end
            s1_v <= (a_gnt && !a_we) || (b_gnt && !b_we);
            s1_b <= b_gnt;
            s2_v <= s1_v;
            s2_b <= s1_b;
            if (a_gnt && a_lock) {own_v, own_b} <= 2'b10;
            else if (b_gnt && b_lock) {own_v, own_b} <= 2'b11;
            else if (!hold) own_v <= 1'b0;
        end
    assign a_rvalid = s2_v && !s2_b;
    assign b_rvalid = s2_v && s2_b;
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;
endmodule

// File: tb/tb_blram_arbiter.sv
// tb_blram_arbiter: directed bench for blram_arbiter with a behavioural one-cycle-read RAM.
module tb_blram_arbiter;
    logic        clk, rst;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [13:0] a_addr, b_addr, mem_addr;
    logic [31:0] a_wdata, b_wdata, mem_wdata, mem_rdata, a_rdata, b_rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic        preload;
    logic [31:0] ram [0:16383];
    int          n_chk, n_fail, na;
    bit          ga [6];
`ifdef BLRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    blram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) ram[69] <= 32'd1;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; na = 0;
        preload = 1'b1; rst = 1'b0;
        {a_req, a_we, a_lock, b_req, b_we, b_lock} = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        for (int i = 0; i < 6; i++) ga[i] = RR ? (i % 2 == 0) : 1'b1;
        tick;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        rst = 1'b1; preload = 1'b0;
        // single A read of 69
        a_req = 1; a_addr = 69; #1;
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_b_gnt", b_gnt, 0);
        tick; a_req = 0; #1;
        chk("t1_mem_addr", mem_addr, 69);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_a_rvalid_early", a_rvalid, 0);
        tick;
        chk("t1_a_rvalid", a_rvalid, 1);
        chk("t1_a_rdata", a_rdata, 1);
        chk("t1_b_rvalid", b_rvalid, 0);
        tick;
        chk("t1_a_rvalid_once", a_rvalid, 0);
        // B write 50 then A read 50
        b_req = 1; b_we = 1; b_addr = 50; b_wdata = 32'hDEADBEEF; #1;
        chk("t2_b_gnt", b_gnt, 1);
        tick; b_req = 0; b_we = 0; a_req = 1; a_addr = 50; #1;
        chk("t2_a_gnt", a_gnt, 1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 50);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick; a_req = 0;
        tick;
        chk("t2_a_rvalid", a_rvalid, 1);
        chk("t2_a_rdata", a_rdata, 32'hDEADBEEF);
        // B write so B is last served before the tie run
        b_req = 1; b_we = 1; b_addr = 100; b_wdata = 32'd7; #1;
        chk("t3_pre_b_gnt", b_gnt, 1);
        tick; b_we = 0;
        for (int i = 0; i < 8; i++) begin
            a_req = (i < 6); b_req = (i < 6); a_addr = 69; b_addr = 50; #1;
            if (i < 6) begin
                chk("t3_a_gnt", a_gnt, ga[i]);
                chk("t3_b_gnt", b_gnt, !ga[i]);
                if (a_gnt) na++;
            end
            if (i >= 2) begin
                chk("t3_a_rvalid", a_rvalid, ga[i-2]);
                chk("t3_b_rvalid", b_rvalid, !ga[i-2]);
                chk("t3_rdata", ga[i-2] ? a_rdata : b_rdata, ga[i-2] ? 32'd1 : 32'hDEADBEEF);
            end
            tick;
        end
        chk("t3_a_count", na, RR ? 3 : 6);
        // lock: A locked read, idle, unlocking write; B waits throughout
        a_req = 1; a_we = 0; a_addr = 69; a_lock = 1; b_req = 1; b_addr = 50; #1;
        chk("t4_lock_a_gnt", a_gnt, 1);
        chk("t4_lock_b_gnt", b_gnt, 0);
        tick; a_req = 0; #1;
        chk("t4_blocked_b_gnt", b_gnt, 0);
        tick; a_req = 1; a_we = 1; a_wdata = 32'h12345678; a_lock = 0; #1;
        chk("t4_wr_a_gnt", a_gnt, 1);
        chk("t4_wr_b_gnt", b_gnt, 0);
        chk("t4_a_rvalid", a_rvalid, 1);
        chk("t4_a_rdata", a_rdata, 1);
        tick; a_req = 0; a_we = 0; #1;
        chk("t4_b_gnt", b_gnt, 1);
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_wdata", mem_wdata, 32'h12345678);
        tick; b_req = 0;
        tick;
        chk("t4_b_rvalid", b_rvalid, 1);
        chk("t4_b_rdata", b_rdata, 32'hDEADBEEF);
        tick;
        // reset one cycle after a locked B read grant
        b_req = 1; b_addr = 50; b_lock = 1; #1;
        chk("t5_b_gnt", b_gnt, 1);
        tick; b_req = 0; b_lock = 0; rst = 0; #1;
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_b_rvalid_r1", b_rvalid, 0);
        tick;
        chk("t5_b_rvalid_r2", b_rvalid, 0);
        chk("t5_mem_we_r2", mem_we, 0);
        tick; rst = 1; #1;
        chk("t5_b_rvalid_r3", b_rvalid, 0);
        a_req = 1; a_addr = 5; b_req = 1; b_addr = 6; b_lock = 1; #1;
        chk("t5_tie_a_gnt", a_gnt, 1);
        chk("t5_tie_b_gnt", b_gnt, 0);
        tick; a_req = 0; b_req = 0; b_lock = 0;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/blram_arbiter.md
# blram_arbiter

Two-requester arbiter that shares the single-port block RAM (`blram`, 32-bit data, one-cycle registered read) between the CPU memory port and a secondary master such as a loader/debug DMA. It accepts requests over a req/gnt handshake, registers the winning command onto the RAM port, and routes the returned read data back to the issuing requester with a fixed two-cycle latency. It sits between `VerySimpleCpu`/secondary master and `blram` in the top level and test bench.

## Interface
- `ADDR_W`, 14, RAM address width (matches `blram` SIZE)
- `DATA_W`, 32, data width

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `a_req`  in  1  port A (CPU) request; held with command fields stable until `a_gnt`
- `a_we`  in  1  port A write (1) / read (0)
- `a_addr`  in  ADDR_W  port A address
- `a_wdata`  in  DATA_W  port A write data
- `a_lock`  in  1  port A holds ownership after its grant (read-modify-write)
- `a_gnt`  out  1  port A command accepted this cycle
- `a_rvalid`  out  1  port A read data valid
- `a_rdata`  out  DATA_W  port A read data
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_lock`, `b_gnt`, `b_rvalid`, `b_rdata`: identical for port B
- `mem_we`  out  1  to `blram` `i_we`
- `mem_addr`  out  ADDR_W  to `blram` `i_addr`
- `mem_wdata`  out  DATA_W  to `blram` `i_ram_data_in`
- `mem_rdata`  in  DATA_W  from `blram` `o_ram_data_out`

## Operation
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `a_rvalid`=`b_rvalid`=0, `a_gnt`=`b_gnt`=0 (combinational from `req`, so 0 whenever both `req` are low), priority pointer = "B last served", owner = none, read-tag pipeline cleared.
- Grant (combinational, cycle N): at most one of `a_gnt`/`b_gnt` high. If owner is locked to X, only X may be granted. Otherwise, single requester wins; on a tie, selection follows the priority policy (see Configuration).
- Issue (edge ending N): winner's `we/addr/wdata` registered onto `mem_*`; pointer updated to the winner. With no grant, `mem_we` registers 0; `mem_addr`/`mem_wdata` hold.
- Read tag: 2-stage shift of {valid, port}; a granted read enters stage 1 at edge N and stage 2 at edge N+1; stage 2 drives `x_rvalid` during cycle N+2.
- `a_rdata`/`b_rdata` = `mem_rdata` (wired); only meaningful when the matching `rvalid` is high.
- Writes complete at grant; no write acknowledge.
- Lock: granted to X with `x_lock`=1 sets owner=X; owner clears on the first cycle `x_lock`=0 (that cycle is already open to arbitration). Lock without a grant has no effect.
- Back-to-back: one command per cycle sustained; read-after-write to the same address returns the new data (RAM write lands at edge N+1, later read samples after it).

## Timing
- Request to grant: 0 cycles (same cycle, combinational, no path from `mem_rdata`).
- Grant to RAM command: 1 edge. Read grant to `rvalid`: cycle N+2, exactly one cycle wide per read.
- Throughput: 1 access/cycle; reads from alternating ports return in issue order.
- Reset asserted mid-operation: all in-flight reads dropped (no `rvalid`), `mem_we` forced 0 immediately (async), lock released.
- `req` dropped before grant: no access issued; not an error.

## Configuration
- `BLRAM_ARB_RR_EN` defined: round-robin; on a tie, the port not served last wins; first tie after reset goes to A.
- Undefined: fixed priority; A always wins ties; B served only when A idle (B may starve by design).

## Test plan
- Single A read of addr 69 (mem=1): `a_gnt` cycle N, `mem_addr`=69 in N+1, `a_rvalid`=1 with `a_rdata`=1 in N+2, `b_rvalid` stays 0.
- B write addr 50 data 0xDEADBEEF then A read addr 50 next cycle: `a_rdata`=0xDEADBEEF two cycles after A grant.
- Both `req` held for 6 cycles, reads: with `BLRAM_ARB_RR_EN` grants A,B,A,B,A,B; without, six A grants and zero B.
- A read with `a_lock`=1, then A write same addr with `a_lock`=0 while B requests throughout: B granted only after the A write cycle.
- Reset pulled low one cycle after B read grant: no `b_rvalid`, `mem_we`=0 during reset, first post-reset tie goes to A.
